llsc_ctrl: RTL and testbench

Sequencer for MIPS LL/SC atomic accesses in the MEM stage. It owns the reservation (LL bit plus reserved word address), drives a req/ack data-memory port for LL reads and SC writes, and stalls the pipeline until each access completes. It evaluates SC success against the reservation and returns the SC result (1/0) or the LL data to writeback. Reservations are cleared by exceptions/ERET and by snooped writes from other bus masters.

---
 rtl/llsc_ctrl.sv | 174 +++++++++++++++++
 tb/tb_llsc_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/llsc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : llsc_ctrl
// Brief    : MEM-stage sequencer for MIPS LL/SC. Owns the LL reservation,
//            issues LL reads / SC writes on a req/ack memory port, stalls
//            the pipeline until each access completes and returns the LL
//            data or SC result (1/0) to writeback.
// Revision : 1.0 - initial release
// ============================================================================
module llsc_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              excpt,
  input  logic              op_ll,
  input  logic              op_sc,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic              res_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              llbit,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              snoop_we,
  input  logic [ADDR_W-1:0] snoop_addr
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LL_RD = 3'd1,
    S_SC_WR = 3'd2,
    S_DONE  = 3'd3,
    S_ABORT = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_res_bit;
  logic [ADDR_W-3:0]   r_res_addr;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;

  logic w_stall, w_res_valid, w_accept_ll, w_accept_sc, w_sc_fail;
  logic w_snoop_hit, w_snoop_ll, w_sc_hit, w_ll_done, w_sc_done, w_busy_ack;
  logic w_unused_snoop_lo;

  // Byte offset of the snooped address plays no part in word matching.
  assign w_unused_snoop_lo = ^snoop_addr[1:0];

  // A snoop on the reserved word, and a snoop on the word an in-flight LL is reading.
  assign w_snoop_hit = snoop_we && (snoop_addr[ADDR_W-1:2] == r_res_addr);
  assign w_snoop_ll  = snoop_we && (snoop_addr[ADDR_W-1:2] == r_mem_addr[ADDR_W-1:2]);
  // SC may only go to memory if the reservation survives this very cycle.
  assign w_sc_hit    = r_res_bit && (r_res_addr == addr[ADDR_W-1:2]) && !w_snoop_hit && !excpt;

  assign w_ll_done  = (r_state == S_LL_RD) && mem_ack && !excpt;
  assign w_sc_done  = (r_state == S_SC_WR) && mem_ack && !excpt;
  assign w_busy_ack = ((r_state == S_LL_RD) || (r_state == S_SC_WR) || (r_state == S_ABORT)) && mem_ack;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode plus combinational stall / result strobe.
  always_comb begin
    w_next      = r_state;
    w_stall     = 1'b0;
    w_res_valid = 1'b0;
    w_accept_ll = 1'b0;
    w_accept_sc = 1'b0;
    w_sc_fail   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!excpt) begin
          if (op_ll) begin
            w_stall     = 1'b1;
            w_accept_ll = 1'b1;
            w_next      = S_LL_RD;
          end else if (op_sc) begin
            w_stall = 1'b1;
            if (w_sc_hit) begin
              w_accept_sc = 1'b1;
              w_next      = S_SC_WR;
            end else begin
              w_sc_fail = 1'b1;
              w_next    = S_DONE;
            end
          end
        end
      end
      S_LL_RD, S_SC_WR: begin
        w_stall = 1'b1;
        // An exception abandons the result but the bus cycle must still finish.
        if (excpt)        w_next = mem_ack ? S_IDLE : S_ABORT;
        else if (mem_ack) w_next = S_DONE;
      end
      S_ABORT: begin
        w_stall = 1'b1;
        if (mem_ack) w_next = S_IDLE;
      end
      S_DONE: begin
        w_res_valid = !excpt;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Memory request registers: launched on acceptance, dropped after ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_accept_ll) begin
      r_mem_req  <= 1'b1;
      r_mem_we   <= 1'b0;
      r_mem_addr <= addr;
    end else if (w_accept_sc) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= 1'b1;
      r_mem_addr  <= addr;
      r_mem_wdata <= wdata;
    end else if (w_busy_ack) begin
      r_mem_req <= 1'b0;
    end
  end

  // Writeback data: LL load data, or the SC success/fail flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_rdata <= '0;
    else if (w_ll_done) r_rdata <= mem_rdata;
    else if (w_sc_done) r_rdata <= {{(DATA_W-1){1'b0}}, 1'b1};
    else if (w_sc_fail) r_rdata <= '0;
  end

  // Reservation: set by a completed LL unless that word is snooped the same
  // cycle; otherwise cleared by exceptions, snoop hits and every SC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_bit  <= 1'b0;
      r_res_addr <= '0;
    end else if (w_ll_done) begin
      r_res_bit  <= !w_snoop_ll;
      r_res_addr <= r_mem_addr[ADDR_W-1:2];
    end else if (excpt || w_snoop_hit || w_sc_fail || ((r_state == S_SC_WR) && mem_ack)) begin
      r_res_bit <= 1'b0;
    end
  end

  assign stall     = w_stall;
  assign res_valid = w_res_valid;
  assign rdata     = r_rdata;
  assign llbit     = r_res_bit;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_llsc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_llsc_ctrl
// Brief    : Self-checking bench for llsc_ctrl. Expected writeback values go
//            into a scoreboard queue when an op is driven and are compared
//            when the DUT strobes res_valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_llsc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        excpt = 1'b0;
  logic        op_ll = 1'b0;
  logic        op_sc = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        stall;
  logic        res_valid;
  logic [31:0] rdata;
  logic        llbit;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        snoop_we = 1'b0;
  logic [31:0] snoop_addr = '0;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  llsc_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .excpt(excpt), .op_ll(op_ll), .op_sc(op_sc),
    .addr(addr), .wdata(wdata), .stall(stall), .res_valid(res_valid),
    .rdata(rdata), .llbit(llbit), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .snoop_we(snoop_we), .snoop_addr(snoop_addr)
  );

  // Drives one LL/SC from an IDLE cycle (called at posedge+1), acts as the
  // memory (ack in the ack_k-th request cycle), optionally snoops on the ack
  // cycle, and returns what it saw. Ends in the IDLE cycle after DONE.
  task automatic do_op(input bit ll, input logic [31:0] a, input logic [31:0] wd,
                       input int ack_k, input logic [31:0] md,
                       input bit snp, input logic [31:0] sa,
                       output bit v, output logic [31:0] rd,
                       output int req_cyc, output int stall_cyc, output bit we_seen);
    op_ll = ll; op_sc = !ll; addr = a; wdata = wd;
    v = 1'b0; rd = '0; req_cyc = 0; stall_cyc = 0; we_seen = 1'b0;
    for (int i = 0; i < 20 && !v; i++) begin
      @(negedge clk);
      if (stall) stall_cyc++;
      if (mem_req) begin
        req_cyc++;
        we_seen   = we_seen | mem_we;
        mem_rdata = md;
        mem_ack   = (req_cyc == ack_k);
        snoop_we  = snp && (req_cyc == ack_k);
        snoop_addr = sa;
      end
      if (res_valid) begin
        v  = 1'b1;
        rd = rdata;
      end
      @(posedge clk); #1;
      mem_ack = 1'b0; snoop_we = 1'b0;
    end
    op_ll = 1'b0; op_sc = 1'b0;
  endtask

  task automatic snoop_once(input logic [31:0] sa);
    snoop_we = 1'b1; snoop_addr = sa;
    @(posedge clk); #1;
    snoop_we = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++; if (stall !== 1'b0)     begin fails++; $display("FAIL reset_stall got=%b exp=0", stall); end
    tests++; if (mem_req !== 1'b0)   begin fails++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    tests++; if (llbit !== 1'b0)     begin fails++; $display("FAIL reset_llbit got=%b exp=0", llbit); end
    tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
    tests++; if (rdata !== 32'h0)    begin fails++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    tests++; if ({mem_we, mem_addr, mem_wdata} !== 65'h0) begin fails++; $display("FAIL reset_mem_regs we=%b a=%h wd=%h exp=0", mem_we, mem_addr, mem_wdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_sc_noresv;
    bit v; logic [31:0] rd, e; int rc, sc; bit we;
    exp_q.push_back(32'h0);
    do_op(1'b0, 32'h200, 32'h1234, 1, 32'h0, 1'b0, 32'h0, v, rd, rc, sc, we);
    e = exp_q.pop_front();
    tests++; if (!v)          begin fails++; $display("FAIL noresv_valid got=0 exp=1"); end
    tests++; if (rd !== e)    begin fails++; $display("FAIL noresv_rdata got=%h exp=%h", rd, e); end
    tests++; if (rc !== 0)    begin fails++; $display("FAIL noresv_mem_req got=%0d cycles exp=0", rc); end
    tests++; if (sc !== 1)    begin fails++; $display("FAIL noresv_stall got=%0d cycles exp=1", sc); end
  endtask

  task automatic test_ll_sc;
    bit v; logic [31:0] rd, e; int rc, sc; bit we;
    exp_q.push_back(32'hDEADBEEF);
    do_op(1'b1, 32'h100, 32'h0, 1, 32'hDEADBEEF, 1'b0, 32'h0, v, rd, rc, sc, we);
    e = exp_q.pop_front();
    tests++; if (!v || rd !== e) begin fails++; $display("FAIL ll_rdata valid=%b got=%h exp=%h", v, rd, e); end
    tests++; if (llbit !== 1'b1) begin fails++; $display("FAIL ll_llbit got=%b exp=1", llbit); end
    tests++; if (sc !== 2 || rc !== 1 || we !== 1'b0) begin fails++; $display("FAIL ll_timing stall=%0d req=%0d we=%b exp 2/1/0", sc, rc, we); end
    exp_q.push_back(32'h1);
    do_op(1'b0, 32'h100, 32'hCAFE0001, 2, 32'h0, 1'b0, 32'h0, v, rd, rc, sc, we);
    e = exp_q.pop_front();
    tests++; if (!v || rd !== e) begin fails++; $display("FAIL sc_rdata valid=%b got=%h exp=%h", v, rd, e); end
    tests++; if (we !== 1'b1 || rc !== 2 || sc !== 3) begin fails++; $display("FAIL sc_write we=%b req=%0d stall=%0d exp 1/2/3", we, rc, sc); end
    tests++; if (mem_addr !== 32'h100 || mem_wdata !== 32'hCAFE0001) begin fails++; $display("FAIL sc_mem_regs a=%h wd=%h exp 100/cafe0001", mem_addr, mem_wdata); end
    tests++; if (llbit !== 1'b0) begin fails++; $display("FAIL sc_llbit got=%b exp=0", llbit); end
  endtask

  task automatic test_addr_mismatch;
    bit v; logic [31:0] rd, e; int rc, sc; bit we;
    exp_q.push_back(32'h11112222);
    do_op(1'b1, 32'h100, 32'h0, 2, 32'h11112222, 1'b0, 32'h0, v, rd, rc, sc, we);
    e = exp_q.pop_front();
    tests++; if (!v || rd !== e) begin fails++; $display("FAIL mm_ll valid=%b got=%h exp=%h", v, rd, e); end
    exp_q.push_back(32'h0);
    do_op(1'b0, 32'h104, 32'h5, 1, 32'h0, 1'b0, 32'h0, v, rd, rc, sc, we);
    e = exp_q.pop_front();
    tests++; if (!v || rd !== e || rc !== 0) begin fails++; $display("FAIL mm_sc valid=%b got=%h req=%0d exp=%h req 0", v, rd, rc, e); end
    tests++; if (llbit !== 1'b0) begin fails++; $display("FAIL mm_llbit got=%b exp=0", llbit); end
  endtask

  task automatic test_snoop;
    bit v; logic [31:0] rd, e; int rc, sc; bit we;
    exp_q.push_back(32'hA5A5A5A5);
    do_op(1'b1, 32'h100, 32'h0, 1, 32'hA5A5A5A5, 1'b0, 32'h0, v, rd, rc, sc, we);
    e = exp_q.pop_front();
    tests++; if (!v || rd !== e) begin fails++; $display("FAIL snp_ll1 valid=%b got=%h exp=%h", v, rd, e); end
    snoop_once(32'h102);
    tests++; if (llbit !== 1'b0) begin fails++; $display("FAIL snp_kill_llbit got=%b exp=0", llbit); end
    exp_q.push_back(32'h0);
    do_op(1'b0, 32'h100, 32'h7, 1, 32'h0, 1'b0, 32'h0, v, rd, rc, sc, we);
    e = exp_q.pop_front();
    tests++; if (!v || rd !== e || rc !== 0) begin fails++; $display("FAIL snp_kill_sc valid=%b got=%h req=%0d exp=%h", v, rd, rc, e); end
    exp_q.push_back(32'h5A5A5A5A);
    do_op(1'b1, 32'h100, 32'h0, 1, 32'h5A5A5A5A, 1'b0, 32'h0, v, rd, rc, sc, we);
    e = exp_q.pop_front();
    tests++; if (!v || rd !== e) begin fails++; $display("FAIL snp_ll2 valid=%b got=%h exp=%h", v, rd, e); end
    snoop_once(32'h104);
    tests++; if (llbit !== 1'b1) begin fails++; $display("FAIL snp_miss_llbit got=%b exp=1", llbit); end
    exp_q.push_back(32'h1);
    do_op(1'b0, 32'h100, 32'h9, 1, 32'h0, 1'b0, 32'h0, v, rd, rc, sc, we);
    e = exp_q.pop_front();
    tests++; if (!v || rd !== e || rc !== 1) begin fails++; $display("FAIL snp_miss_sc valid=%b got=%h req=%0d exp=%h", v, rd, rc, e); end
  endtask

  task automatic test_snoop_at_ack;
    bit v; logic [31:0] rd, e; int rc, sc; bit we;
    exp_q.push_back(32'h0BADF00D);
    do_op(1'b1, 32'h100, 32'h0, 1, 32'h0BADF00D, 1'b1, 32'h100, v, rd, rc, sc, we);
    e = exp_q.pop_front();
    tests++; if (!v || rd !== e) begin fails++; $display("FAIL snpack_ll valid=%b got=%h exp=%h", v, rd, e); end
    tests++; if (llbit !== 1'b0) begin fails++; $display("FAIL snpack_llbit got=%b exp=0", llbit); end
  endtask

  task automatic test_exception;
    bit v; logic [31:0] rd, e; int rc, sc; bit we;
    int req_cyc = 0; int rv_cnt = 0; int abort_stall = 0;
    // Establish a reservation first so the exception has something to clear.
    exp_q.push_back(32'h13579BDF);
    do_op(1'b1, 32'h100, 32'h0, 1, 32'h13579BDF, 1'b0, 32'h0, v, rd, rc, sc, we);
    e = exp_q.pop_front();
    tests++; if (!v || rd !== e || llbit !== 1'b1) begin fails++; $display("FAIL exc_pre_ll valid=%b got=%h llbit=%b exp=%h/1", v, rd, llbit, e); end
    op_ll = 1'b1; addr = 32'h100;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (res_valid) rv_cnt++;
      if (mem_req) begin
        req_cyc++;
        if (req_cyc == 2) excpt = 1'b1;
        if (req_cyc == 3) begin mem_ack = 1'b1; mem_rdata = 32'hFFFF0000; if (stall) abort_stall++; end
      end
      @(posedge clk); #1;
      if (excpt) op_ll = 1'b0;
      excpt = 1'b0; mem_ack = 1'b0;
    end
    tests++; if (req_cyc !== 3)   begin fails++; $display("FAIL exc_req_hold got=%0d cycles exp=3", req_cyc); end
    tests++; if (rv_cnt !== 0)    begin fails++; $display("FAIL exc_res_valid got=%0d pulses exp=0", rv_cnt); end
    tests++; if (abort_stall !== 1) begin fails++; $display("FAIL exc_abort_stall got=%0d exp=1", abort_stall); end
    tests++; if (llbit !== 1'b0)  begin fails++; $display("FAIL exc_llbit got=%b exp=0", llbit); end
    exp_q.push_back(32'h0);
    do_op(1'b0, 32'h100, 32'h3, 1, 32'h0, 1'b0, 32'h0, v, rd, rc, sc, we);
    e = exp_q.pop_front();
    tests++; if (!v || rd !== e || rc !== 0) begin fails++; $display("FAIL exc_sc valid=%b got=%h req=%0d exp=%h", v, rd, rc, e); end
  endtask

  task automatic test_back_to_back;
    bit v; logic [31:0] rd, e; int rc, sc; bit we;
    // SC fail immediately followed by LL then SC, with no idle gaps.
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h76543210);
    exp_q.push_back(32'h1);
    do_op(1'b0, 32'h300, 32'h0, 1, 32'h0, 1'b0, 32'h0, v, rd, rc, sc, we);
    e = exp_q.pop_front();
    tests++; if (!v || rd !== e) begin fails++; $display("FAIL b2b_sc0 valid=%b got=%h exp=%h", v, rd, e); end
    do_op(1'b1, 32'h300, 32'h0, 1, 32'h76543210, 1'b0, 32'h0, v, rd, rc, sc, we);
    e = exp_q.pop_front();
    tests++; if (!v || rd !== e || sc !== 2) begin fails++; $display("FAIL b2b_ll valid=%b got=%h stall=%0d exp=%h/2", v, rd, sc, e); end
    do_op(1'b0, 32'h300, 32'h42, 1, 32'h0, 1'b0, 32'h0, v, rd, rc, sc, we);
    e = exp_q.pop_front();
    tests++; if (!v || rd !== e || we !== 1'b1) begin fails++; $display("FAIL b2b_sc1 valid=%b got=%h we=%b exp=%h", v, rd, we, e); end
  endtask

  task automatic test_async_rst;
    bit v; logic [31:0] rd, e; int rc, sc; bit we;
    exp_q.push_back(32'h24681357);
    do_op(1'b1, 32'h400, 32'h0, 1, 32'h24681357, 1'b0, 32'h0, v, rd, rc, sc, we);
    e = exp_q.pop_front();
    tests++; if (!v || rd !== e) begin fails++; $display("FAIL rst_ll valid=%b got=%h exp=%h", v, rd, e); end
    op_sc = 1'b1; addr = 32'h400; wdata = 32'h99;
    @(posedge clk); #1;
    tests++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin fails++; $display("FAIL rst_sc_issue req=%b we=%b exp 1/1", mem_req, mem_we); end
    #2 rst = 1'b1; op_sc = 1'b0;
    #1;
    tests++; if (mem_req !== 1'b0 || stall !== 1'b0) begin fails++; $display("FAIL rst_async req=%b stall=%b exp 0/0", mem_req, stall); end
    tests++; if (llbit !== 1'b0 || mem_addr !== 32'h0) begin fails++; $display("FAIL rst_async_state llbit=%b addr=%h exp 0/0", llbit, mem_addr); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_sc_noresv;
    test_ll_sc;
    test_addr_mismatch;
    test_snoop;
    test_snoop_at_ack;
    test_exception;
    test_back_to_back;
    test_async_rst;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
